// File: rtl/pass_update_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pass_pkg
// Brief    : Shared types and helpers for the password write-back path.
// Revision : 1.0 - initial release
// ============================================================================
package pass_pkg;

    localparam int          WIDTH     = 32;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GEN     = 3'd1,
        WR_LOCK = 3'd2,
        WR_KEY  = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_t;

    // Right-shifting Galois step; a nonzero state never maps to zero.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pass_update_if.sv
`default_nettype none
// ============================================================================
// Module   : pass_update_if
// Brief    : Lock/Key write bus: two req/ack pairs sharing one data word.
// Revision : 1.0 - initial release
// ============================================================================
interface pass_update_if #(
    parameter int WIDTH = pass_pkg::WIDTH
);
    logic             lock_wr_req;
    logic             lock_wr_ack;
    logic             key_wr_req;
    logic             key_wr_ack;
    logic [WIDTH-1:0] newPass;

    modport master (
        output lock_wr_req,
        output key_wr_req,
        output newPass,
        input  lock_wr_ack,
        input  key_wr_ack
    );

    modport slave (
        input  lock_wr_req,
        input  key_wr_req,
        input  newPass,
        output lock_wr_ack,
        output key_wr_ack
    );
endinterface
`default_nettype wire

// File: rtl/pass_update_wr_port.sv
`default_nettype none
// ============================================================================
// Module   : pass_wr_port
// Brief    : One req/ack write target with per-attempt timeout and retries.
// Revision : 1.0 - initial release
// ============================================================================
module pass_wr_port #(
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  wire  clk,
    input  wire  reset,
    input  logic i_start,
    input  logic i_ack,
    output logic o_req,
    output logic o_done,
    output logic o_fail
);

    localparam int             TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int             RW         = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0]  RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [RW-1:0]  RETRY_MAX  = RW'(MAX_RETRY);

    logic          r_req;
    logic          r_gap;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_retry;
    logic          w_timeout;

    // An ack on the timeout cycle still counts as success.
    assign w_timeout = r_req & ~i_ack & (r_timer == TIMER_LAST);
    assign o_done    = r_req & i_ack;
    assign o_fail    = w_timeout & (r_retry == RETRY_LAST);
    assign o_req     = r_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req   <= 1'b0;
            r_gap   <= 1'b0;
            r_timer <= '0;
            r_retry <= '0;
        end else if (i_start) begin
            r_req   <= 1'b1;
            r_gap   <= 1'b0;
            r_timer <= '0;
            r_retry <= '0;
        end else if (r_req) begin
            if (i_ack) begin
                r_req   <= 1'b0;
                r_timer <= '0;
            end else if (r_timer == TIMER_LAST) begin
                r_req   <= 1'b0;
                r_timer <= '0;
                r_retry <= (r_retry == RETRY_MAX) ? RETRY_MAX : r_retry + 1'b1;
                r_gap   <= (r_retry != RETRY_LAST);
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end else if (r_gap) begin
            r_gap <= 1'b0;
            r_req <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pass_update.sv
`default_nettype none
// ============================================================================
// Module   : pass_update
// Brief    : Generates a fresh password after a match and writes Lock then Key.
// Revision : 1.0 - initial release
// ============================================================================
module pass_update #(
    parameter int          WIDTH     = pass_pkg::WIDTH,
    parameter logic [31:0] SEED      = 32'hACE1_2345,
    parameter int          TIMEOUT   = 16,
    parameter int          MAX_RETRY = 3
) (
    input  wire              clk,
    input  wire              reset,
    input  logic             unlockDoor,
    input  logic             readLock,
    input  logic             readKey,
    input  logic [WIDTH-1:0] oldPass,
    pass_update_if.master    wrBus,
    output logic             busy,
    output logic             update_done,
    output logic             update_err
);
    import pass_pkg::*;

    state_t           r_state;
    logic [31:0]      r_lfsr;
    logic             r_unlockPrev;
    logic [WIDTH-1:0] r_newPass;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_keyStart;

    logic w_idleLike;
    logic w_trigger;
    logic w_genMatch;
    logic w_lockStart;
    logic w_lockDone;
    logic w_lockFail;
    logic w_keyDone;
    logic w_keyFail;

    assign w_idleLike  = (r_state == IDLE) | (r_state == DONE) | (r_state == ERR);
    assign w_trigger   = unlockDoor & ~r_unlockPrev & ~readLock & ~readKey & w_idleLike;
    assign w_genMatch  = (r_lfsr[WIDTH-1:0] == oldPass);
    assign w_lockStart = (r_state == GEN) & ~w_genMatch;

    pass_wr_port #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) u_lockPort (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_lockStart),
        .i_ack   (wrBus.lock_wr_ack),
        .o_req   (wrBus.lock_wr_req),
        .o_done  (w_lockDone),
        .o_fail  (w_lockFail)
    );

    // Key request starts one cycle after the Lock request drops.
    pass_wr_port #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) u_keyPort (
        .clk     (clk),
        .reset   (reset),
        .i_start (r_keyStart),
        .i_ack   (wrBus.key_wr_ack),
        .o_req   (wrBus.key_wr_req),
        .o_done  (w_keyDone),
        .o_fail  (w_keyFail)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lfsr       <= SEED;
            r_unlockPrev <= 1'b0;
            r_newPass    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_keyStart   <= 1'b0;
        end else begin
            r_lfsr       <= lfsr_next(r_lfsr);
            r_unlockPrev <= unlockDoor;
            r_keyStart   <= w_lockDone;
            r_done       <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (w_trigger) begin
                        r_state <= GEN;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                    end else if (r_state == DONE) begin
                        r_state <= IDLE;
                    end
                end
                GEN: begin
                    // A candidate equal to the current password is skipped.
                    r_newPass <= r_lfsr[WIDTH-1:0];
                    if (!w_genMatch) begin
                        r_state <= WR_LOCK;
                    end
                end
                WR_LOCK: begin
                    if (w_lockDone) begin
                        r_state <= WR_KEY;
                    end else if (w_lockFail) begin
                        r_state <= ERR;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end
                WR_KEY: begin
                    if (w_keyDone) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_keyFail) begin
                        r_state <= ERR;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wrBus.newPass = r_newPass;
    assign busy          = r_busy;
    assign update_done   = r_done;
    assign update_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pass_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_pass_update
// Brief    : Randomized scoreboard bench for pass_update with ack responders.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pass_update;

    localparam int          W    = 32;
    localparam logic [31:0] SEED = 32'hACE1_2345;
    localparam int          TO   = 16;
    localparam int          MR   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        unlockDoor = 1'b0;
    logic        readLock = 1'b0;
    logic        readKey = 1'b0;
    logic [31:0] oldPass = 32'h0;
    logic        busy;
    logic        update_done;
    logic        update_err;

    pass_update_if #(.WIDTH(W)) bus();

    pass_update #(
        .WIDTH     (W),
        .SEED      (SEED),
        .TIMEOUT   (TO),
        .MAX_RETRY (MR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .unlockDoor  (unlockDoor),
        .readLock    (readLock),
        .readKey     (readKey),
        .oldPass     (oldPass),
        .wrBus       (bus.master),
        .busy        (busy),
        .update_done (update_done),
        .update_err  (update_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Polynomial x^32 + x^22 + x^2 + x + 1, shifted toward bit 0.
    function automatic logic [31:0] polyStep(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) begin
            r[31] = ~r[31];
            r[21] = ~r[21];
            r[1]  = ~r[1];
            r[0]  = ~r[0];
        end
        return r;
    endfunction

    logic [31:0] mLfsr = SEED;
    always @(posedge clk) mLfsr <= reset ? SEED : polyStep(mLfsr);

    // Responders: ack on attempt >= A, once the request has been up D cycles.
    int lockA = 1, lockD = 0, keyA = 1, keyD = 0;
    int lockBase = 0, keyBase = 0;
    int lockRise[$], lockFall[$], keyRise[$], keyFall[$];
    logic lockPrev = 1'b0, keyPrev = 1'b0;
    int lockCnt = 0, keyCnt = 0;

    always @(negedge clk) begin
        if (bus.lock_wr_req && !lockPrev) begin
            lockRise.push_back(cyc);
            lockCnt = 0;
        end else if (bus.lock_wr_req) begin
            lockCnt++;
        end
        if (!bus.lock_wr_req && lockPrev) lockFall.push_back(cyc);
        lockPrev = bus.lock_wr_req;
        bus.lock_wr_ack = bus.lock_wr_req && (lockRise.size() - lockBase >= lockA) && (lockCnt >= lockD);

        if (bus.key_wr_req && !keyPrev) begin
            keyRise.push_back(cyc);
            keyCnt = 0;
        end else if (bus.key_wr_req) begin
            keyCnt++;
        end
        if (!bus.key_wr_req && keyPrev) keyFall.push_back(cyc);
        keyPrev = bus.key_wr_req;
        bus.key_wr_ack = bus.key_wr_req && (keyRise.size() - keyBase >= keyA) && (keyCnt >= keyD);
    end

    typedef struct {
        bit          isErr;
        logic [31:0] pass;
        logic [31:0] old;
        int          lat;
        int          tTrig;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int protoErr = 0;
    int stableErr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports done or error.
    logic errPrev = 1'b0;
    bit haveRef = 1'b0;
    logic [31:0] refPass = 32'h0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.lock_wr_req && bus.key_wr_req) protoErr++;
            if ((bus.lock_wr_req || bus.key_wr_req) && !busy) protoErr++;
            if (bus.lock_wr_req || bus.key_wr_req) begin
                if (!haveRef) begin
                    refPass = bus.newPass;
                    haveRef = 1'b1;
                end else if (bus.newPass !== refPass) begin
                    stableErr++;
                end
            end
            if (!busy) haveRef = 1'b0;

            if (update_done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: update_done at cycle %0d with nothing pending", cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_not_err", {63'h0, e.isErr}, 64'h0);
                    check("newPass", {32'h0, bus.newPass}, {32'h0, e.pass});
                    check("newPass_ne_old", {63'h0, bus.newPass != e.old}, 64'h1);
                    check("busy_at_done", {63'h0, busy}, 64'h0);
                    if (e.lat >= 0) check("done_latency", 64'(cyc - e.tTrig), 64'(e.lat));
                end
            end
            if (update_err && !errPrev) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_err: update_err at cycle %0d with nothing pending", cyc);
                end else begin
                    e = sb.pop_front();
                    check("err_expected", {63'h0, e.isErr}, 64'h1);
                    check("newPass_at_err", {32'h0, bus.newPass}, {32'h0, e.pass});
                    if (e.lat >= 0) check("err_latency", 64'(cyc - e.tTrig), 64'(e.lat));
                end
            end
        end
        errPrev = update_err;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doTrigger(input logic [31:0] op, input bit forceEq,
                             input int la, input int ld, input int ka, input int kd,
                             input int lat, output int tT);
        logic [31:0] l1;
        exp_t e;
        lockA = la;  lockD = ld;  keyA = ka;  keyD = kd;
        lockBase = lockRise.size();
        keyBase  = keyRise.size();
        l1 = polyStep(mLfsr);
        if (forceEq) op = l1;
        oldPass = op;
        e.pass  = (l1 == op) ? polyStep(l1) : l1;
        e.isErr = !((la <= MR) && (ld < TO) && (ka <= MR) && (kd < TO));
        e.old   = op;
        e.lat   = lat;
        e.tTrig = cyc;
        tT      = cyc;
        sb.push_back(e);
        unlockDoor = 1'b1;
        tick();
        unlockDoor = 1'b0;
    endtask

    task automatic waitIdle(input int bound, input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < bound) begin
            tick();
            n++;
        end
        if (sb.size() != 0 || busy) begin
            tests++;
            fails++;
            $display("FAIL %s: no completion within %0d cycles, pending=%0d", name, bound, sb.size());
            sb.delete();
        end
    endtask

    int tN, b, kb, n, lw, kw, la, ld, ka, kd;

    initial begin
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_lock_req", {63'h0, bus.lock_wr_req}, 64'h0);
        check("rst_key_req", {63'h0, bus.key_wr_req}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, update_done}, 64'h0);
        check("rst_err", {63'h0, update_err}, 64'h0);
        check("rst_newPass", {32'h0, bus.newPass}, 64'h0);
        tick();

        // Immediate acks, then a second trigger landing in the DONE cycle.
        doTrigger(32'h0, 1'b0, 1, 0, 1, 0, 5, tN);
        b = lockBase;
        tick(4);
        check("lock_req_latency", 64'(lockRise[b] - tN), 64'd2);
        check("newPass_nonzero", {63'h0, bus.newPass != 0}, 64'h1);
        doTrigger($urandom, 1'b0, 1, 0, 1, 0, 5, tN);
        waitIdle(50, "immediate_acks");

        // Lock never acks: three windows, then error.
        tick(2);
        doTrigger($urandom, 1'b0, 99, 0, 1, 0, 52, tN);
        waitIdle(200, "lock_timeout");
        check("timeout_windows", 64'(lockRise.size() - lockBase), 64'd3);
        if (lockRise.size() - lockBase >= 3 && lockFall.size() - lockBase >= 3) begin
            for (int i = 0; i < 3; i++)
                check("window_len", 64'(lockFall[lockBase + i] - lockRise[lockBase + i]), 64'd16);
            for (int i = 0; i < 2; i++)
                check("window_gap", 64'(lockRise[lockBase + i + 1] - lockFall[lockBase + i]), 64'd1);
        end
        check("timeout_err", {63'h0, update_err}, 64'h1);
        check("timeout_busy", {63'h0, busy}, 64'h0);
        check("timeout_no_key", 64'(keyRise.size() - keyBase), 64'd0);

        // From ERR: lock acks on 2nd attempt, key after 5 cycles.
        tick(3);
        doTrigger($urandom, 1'b0, 2, $urandom_range(0, TO - 1), 1, 5, -1, tN);
        check("err_cleared", {63'h0, update_err}, 64'h0);
        waitIdle(120, "retry_once");
        check("lock_attempts", 64'(lockRise.size() - lockBase), 64'd2);
        check("key_attempts", 64'(keyRise.size() - keyBase), 64'd1);

        // Candidate collides with oldPass: GEN holds an extra cycle.
        tick(2);
        doTrigger(32'h0, 1'b1, 1, 0, 1, 0, 6, tN);
        b = lockBase;
        waitIdle(50, "gen_collision");
        check("gen_two_cycles", 64'(lockRise[b] - tN), 64'd3);

        // Rejected triggers: readLock high, no rising edge, readKey high.
        tick(2);
        b = lockRise.size();
        readLock = 1'b1;
        unlockDoor = 1'b1;
        tick(10);
        readLock = 1'b0;
        tick(10);
        unlockDoor = 1'b0;
        tick();
        readKey = 1'b1;
        unlockDoor = 1'b1;
        tick();
        unlockDoor = 1'b0;
        readKey = 1'b0;
        tick(5);
        check("rejected_no_req", 64'(lockRise.size() - b), 64'd0);
        check("rejected_not_busy", {63'h0, busy}, 64'h0);

        // Trigger while busy is ignored.
        doTrigger($urandom, 1'b0, 1, 3, 1, 8, -1, tN);
        tick(4);
        unlockDoor = 1'b1;
        tick();
        unlockDoor = 1'b0;
        waitIdle(80, "busy_trigger");
        tick(10);
        check("busy_trig_lock_once", 64'(lockRise.size() - lockBase), 64'd1);
        check("busy_trig_key_once", 64'(keyRise.size() - keyBase), 64'd1);
        check("busy_trig_no_pending", 64'(sb.size()), 64'd0);

        // Reset during WR_KEY aborts everything.
        doTrigger($urandom, 1'b0, 1, 0, 99, 0, -1, tN);
        n = 0;
        while (!bus.key_wr_req && n < 20) begin
            tick();
            n++;
        end
        check("key_req_seen", {63'h0, bus.key_wr_req}, 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_lock_req", {63'h0, bus.lock_wr_req}, 64'h0);
        check("abort_key_req", {63'h0, bus.key_wr_req}, 64'h0);
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_err", {63'h0, update_err}, 64'h0);
        tick();
        doTrigger(32'h0, 1'b0, 1, 0, 1, 0, 5, tN);
        waitIdle(50, "after_reset");

        // Randomized updates.
        for (int i = 0; i < 24; i++) begin
            tick($urandom_range(1, 4));
            la = $urandom_range(1, 4);
            ld = $urandom_range(0, 18);
            ka = $urandom_range(1, 4);
            kd = $urandom_range(0, 18);
            doTrigger($urandom, $urandom_range(0, 3) == 0, la, ld, ka, kd, -1, tN);
            waitIdle(300, "random_update");
            lw = (ld < TO && la <= MR) ? la : MR;
            kw = (ld < TO && la <= MR) ? ((kd < TO && ka <= MR) ? ka : MR) : 0;
            check("rand_lock_windows", 64'(lockRise.size() - lockBase), 64'(lw));
            check("rand_key_windows", 64'(keyRise.size() - keyBase), 64'(kw));
        end

        tick(5);
        check("protocol_violations", 64'(protoErr), 64'd0);
        check("newPass_stability", 64'(stableErr), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
